// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with halt drain control.
// Squashes younger instructions while a captured halt drains through MEM and WB.
module ex_mem_stage #(
    parameter int DATA_W       = 16,
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    input  logic              in_MemWrite,
    input  logic              in_Halt,
    input  logic              in_PCtoReg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_dest_reg,
    input  logic [DATA_W-1:0] in_pc_next,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic              out_RegWrite,
    output logic              out_MemtoReg,
    output logic              out_MemWrite,
    output logic              out_PCtoReg,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [DATA_W-1:0] out_pc_next,
    output logic [REG_W-1:0]  out_dest_reg,
    output logic              halt_pending,
    output logic              halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              regWrite_q, regWrite_d;
    logic              memtoReg_q, memtoReg_d;
    logic              memWrite_q, memWrite_d;
    logic              pcToReg_q, pcToReg_d;
    logic [DATA_W-1:0] aluResult_q, aluResult_d;
    logic [DATA_W-1:0] storeData_q, storeData_d;
    logic [DATA_W-1:0] pcNext_q, pcNext_d;
    logic [REG_W-1:0]  destReg_q, destReg_d;

    logic capture;
    logic advance;
    logic validEff;

    // Flush overrides stall, so a flushed cycle still counts as a drain step.
    assign capture  = !flush && !stall;
    assign advance  = flush || !stall;
    assign validEff = in_valid && (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        regWrite_d  = regWrite_q;
        memtoReg_d  = memtoReg_q;
        memWrite_d  = memWrite_q;
        pcToReg_d   = pcToReg_q;
        aluResult_d = aluResult_q;
        storeData_d = storeData_q;
        pcNext_d    = pcNext_q;
        destReg_d   = destReg_q;

        if (flush) begin
            valid_d    = 1'b0;
            regWrite_d = 1'b0;
            memtoReg_d = 1'b0;
            memWrite_d = 1'b0;
            pcToReg_d  = 1'b0;
        end else if (!stall) begin
            valid_d     = validEff;
            regWrite_d  = in_RegWrite && validEff;
            memtoReg_d  = in_MemtoReg && validEff;
            memWrite_d  = in_MemWrite && validEff;
            pcToReg_d   = in_PCtoReg && validEff;
            aluResult_d = in_alu_result;
            storeData_d = in_store_data;
            pcNext_d    = in_pc_next;
            destReg_d   = in_dest_reg;
        end

        case (state_q)
            RUN: begin
                if (capture && in_valid && in_Halt) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            DRAIN: begin
                if (advance) begin
                    if (cnt_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            regWrite_q  <= 1'b0;
            memtoReg_q  <= 1'b0;
            memWrite_q  <= 1'b0;
            pcToReg_q   <= 1'b0;
            aluResult_q <= '0;
            storeData_q <= '0;
            pcNext_q    <= '0;
            destReg_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            regWrite_q  <= regWrite_d;
            memtoReg_q  <= memtoReg_d;
            memWrite_q  <= memWrite_d;
            pcToReg_q   <= pcToReg_d;
            aluResult_q <= aluResult_d;
            storeData_q <= storeData_d;
            pcNext_q    <= pcNext_d;
            destReg_q   <= destReg_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_RegWrite   = regWrite_q;
    assign out_MemtoReg   = memtoReg_q;
    assign out_MemWrite   = memWrite_q;
    assign out_PCtoReg    = pcToReg_q;
    assign out_alu_result = aluResult_q;
    assign out_store_data = storeData_q;
    assign out_pc_next    = pcNext_q;
    assign out_dest_reg   = destReg_q;
    assign halt_pending   = (state_q == DRAIN);
    assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage with default parameters.
// Expected values are hand-computed for DRAIN_CYCLES=2.
module tb_ex_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_RegWrite;
    logic        in_MemtoReg;
    logic        in_MemWrite;
    logic        in_Halt;
    logic        in_PCtoReg;
    logic [15:0] in_alu_result;
    logic [15:0] in_store_data;
    logic [3:0]  in_dest_reg;
    logic [15:0] in_pc_next;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_RegWrite;
    logic        out_MemtoReg;
    logic        out_MemWrite;
    logic        out_PCtoReg;
    logic [15:0] out_alu_result;
    logic [15:0] out_store_data;
    logic [15:0] out_pc_next;
    logic [3:0]  out_dest_reg;
    logic        halt_pending;
    logic        halted;

    int checks;
    int failures;

    ex_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_RegWrite    (in_RegWrite),
        .in_MemtoReg    (in_MemtoReg),
        .in_MemWrite    (in_MemWrite),
        .in_Halt        (in_Halt),
        .in_PCtoReg     (in_PCtoReg),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_dest_reg    (in_dest_reg),
        .in_pc_next     (in_pc_next),
        .stall          (stall),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_RegWrite   (out_RegWrite),
        .out_MemtoReg   (out_MemtoReg),
        .out_MemWrite   (out_MemWrite),
        .out_PCtoReg    (out_PCtoReg),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_pc_next    (out_pc_next),
        .out_dest_reg   (out_dest_reg),
        .halt_pending   (halt_pending),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rst           = 1'b0;
        in_valid      = 1'b0;
        in_RegWrite   = 1'b0;
        in_MemtoReg   = 1'b0;
        in_MemWrite   = 1'b0;
        in_Halt       = 1'b0;
        in_PCtoReg    = 1'b0;
        in_alu_result = 16'h0000;
        in_store_data = 16'h0000;
        in_dest_reg   = 4'h0;
        in_pc_next    = 16'h0000;
        stall         = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkControls(input string tag, input logic [4:0] exp);
        checkOutput(tag, {27'd0, out_valid, out_RegWrite, out_MemtoReg, out_MemWrite, out_PCtoReg},
                    {27'd0, exp});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clearInputs();

        // Reset with busy inputs: everything must come up zero.
        rst = 1'b1; in_valid = 1'b1; in_RegWrite = 1'b1; in_MemWrite = 1'b1;
        in_alu_result = 16'hFFFF; in_store_data = 16'hAAAA; in_dest_reg = 4'hF; in_pc_next = 16'h1111;
        applyStimulus();
        checkControls("reset_ctrl", 5'b00000);
        checkOutput("reset_alu", out_alu_result, 0);
        checkOutput("reset_store", out_store_data, 0);
        checkOutput("reset_pc", out_pc_next, 0);
        checkOutput("reset_dest", out_dest_reg, 0);
        checkOutput("reset_status", {halt_pending, halted}, 0);

        // Normal capture.
        clearInputs();
        in_valid = 1'b1; in_RegWrite = 1'b1; in_alu_result = 16'h1234; in_dest_reg = 4'd5;
        in_store_data = 16'h5555; in_pc_next = 16'h0010;
        applyStimulus();
        checkControls("norm_ctrl", 5'b11000);
        checkOutput("norm_alu", out_alu_result, 16'h1234);
        checkOutput("norm_dest", out_dest_reg, 5);
        checkOutput("norm_store", out_store_data, 16'h5555);
        checkOutput("norm_pc", out_pc_next, 16'h0010);

        // Controls gated by in_valid, data still captured.
        clearInputs();
        in_RegWrite = 1'b1; in_MemtoReg = 1'b1; in_MemWrite = 1'b1; in_PCtoReg = 1'b1;
        in_alu_result = 16'h0042;
        applyStimulus();
        checkControls("gate_ctrl", 5'b00000);
        checkOutput("gate_alu", out_alu_result, 16'h0042);

        // Stall hold for three cycles.
        clearInputs();
        in_valid = 1'b1; in_MemtoReg = 1'b1; in_alu_result = 16'hBEEF;
        applyStimulus();
        checkOutput("load_beef", out_alu_result, 16'hBEEF);
        in_alu_result = 16'h0001; in_MemtoReg = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_alu", out_alu_result, 16'hBEEF);
            checkControls("stall_ctrl", 5'b10100);
        end
        stall = 1'b0;
        applyStimulus();
        checkOutput("unstall_alu", out_alu_result, 16'h0001);
        checkControls("unstall_ctrl", 5'b10000);

        // Flush beats stall; data registers hold.
        clearInputs();
        in_valid = 1'b1; in_MemWrite = 1'b1; in_store_data = 16'hAAAA;
        applyStimulus();
        checkControls("mw_ctrl", 5'b10010);
        flush = 1'b1; stall = 1'b1; in_store_data = 16'h7777;
        applyStimulus();
        checkControls("flush_ctrl", 5'b00000);
        checkOutput("flush_store", out_store_data, 16'hAAAA);

        // Flushed and stalled halts do not leave RUN.
        clearInputs();
        in_valid = 1'b1; in_Halt = 1'b1; flush = 1'b1;
        applyStimulus();
        checkOutput("flush_halt", {halt_pending, halted}, 0);
        flush = 1'b0; stall = 1'b1;
        applyStimulus();
        checkOutput("stall_halt", {halt_pending, halted}, 0);

        // Halt drain: captured at N, halted after N+2.
        clearInputs();
        in_valid = 1'b1; in_Halt = 1'b1; in_RegWrite = 1'b1; in_PCtoReg = 1'b1; in_pc_next = 16'h0100;
        applyStimulus();
        checkOutput("drainN_status", {halt_pending, halted}, 2'b10);
        checkControls("drainN_ctrl", 5'b11001);
        checkOutput("drainN_pc", out_pc_next, 16'h0100);
        clearInputs();
        in_valid = 1'b1; in_RegWrite = 1'b1; in_alu_result = 16'h9999;
        applyStimulus();
        checkOutput("drainN1_status", {halt_pending, halted}, 2'b10);
        checkControls("drainN1_ctrl", 5'b00000);
        checkOutput("drainN1_alu", out_alu_result, 16'h9999);
        applyStimulus();
        checkOutput("drainN2_status", {halt_pending, halted}, 2'b01);
        checkControls("drainN2_ctrl", 5'b00000);
        applyStimulus();
        checkOutput("halted_hold", {halt_pending, halted}, 2'b01);

        // Reset out of HALTED, then a normal capture.
        clearInputs();
        rst = 1'b1; in_valid = 1'b1; in_alu_result = 16'h5A5A;
        applyStimulus();
        checkOutput("rsth_status", {halt_pending, halted}, 0);
        checkControls("rsth_ctrl", 5'b00000);
        checkOutput("rsth_data", {out_alu_result, out_store_data}, 0);
        checkOutput("rsth_pc", out_pc_next, 0);
        clearInputs();
        in_valid = 1'b1; in_RegWrite = 1'b1; in_alu_result = 16'h4321; in_dest_reg = 4'd3;
        applyStimulus();
        checkControls("post_rst_ctrl", 5'b11000);
        checkOutput("post_rst_alu", out_alu_result, 16'h4321);
        checkOutput("post_rst_dest", out_dest_reg, 3);

        // Halt with stall at N+1 and flush at N+2: halted after N+3.
        clearInputs();
        in_valid = 1'b1; in_Halt = 1'b1;
        applyStimulus();
        checkOutput("hs_N", {halt_pending, halted}, 2'b10);
        clearInputs();
        stall = 1'b1;
        applyStimulus();
        checkOutput("hs_N1", {halt_pending, halted}, 2'b10);
        stall = 1'b0; flush = 1'b1;
        applyStimulus();
        checkOutput("hs_N2", {halt_pending, halted}, 2'b10);
        flush = 1'b0;
        applyStimulus();
        checkOutput("hs_N3", {halt_pending, halted}, 2'b01);

        // Reset mid-drain discards that cycle's inputs.
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        clearInputs();
        in_valid = 1'b1; in_Halt = 1'b1;
        applyStimulus();
        checkOutput("md_pending", {halt_pending, halted}, 2'b10);
        rst = 1'b1; in_Halt = 1'b0; in_RegWrite = 1'b1; in_alu_result = 16'h3C3C;
        applyStimulus();
        checkOutput("md_status", {halt_pending, halted}, 0);
        checkControls("md_ctrl", 5'b00000);
        checkOutput("md_alu", out_alu_result, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
